// File: rtl/shift_row_unit.sv
// Registered Rijndael row-rotation stage (ShiftRows / InvShiftRows, per-beat direction)
// with a 2-entry valid/ready output queue.
module shift_row_unit #(
  parameter int NB = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [0:32*NB-1]  in_state,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:32*NB-1]  out_state,
  output logic              out_inv,
  output logic [1:0]        level
);

  localparam int W = 32 * NB;

  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $error("shift_row_unit: NB must be 4, 6 or 8");
  end

  // Rows 2 and 3 rotate one extra column for the 256-bit-block variant.
  function automatic int row_shift(input int r);
    if (NB == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  logic [0:W-1] shifted;

  always_comb begin
    shifted = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (in_inv)
          shifted[8*(4*c+r) +: 8] = in_state[8*(4*((c - row_shift(r) + NB) % NB) + r) +: 8];
        else
          shifted[8*(4*c+r) +: 8] = in_state[8*(4*((c + row_shift(r)) % NB) + r) +: 8];
      end
    end
  end

  logic [0:W-1] head_state_q, head_state_d;
  logic [0:W-1] tail_state_q, tail_state_d;
  logic         head_inv_q, head_inv_d;
  logic         tail_inv_q, tail_inv_d;
  logic [1:0]   level_q, level_d;
  logic         push, pop;

  assign in_ready  = (level_q != 2'd2) && !flush;
  assign out_valid = (level_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
  always_comb begin
    head_state_d = head_state_q;
    head_inv_d   = head_inv_q;
    tail_state_d = tail_state_q;
    tail_inv_d   = tail_inv_q;
    level_d      = level_q;
    if (flush) begin
      head_state_d = '0;
      head_inv_d   = 1'b0;
      tail_state_d = '0;
      tail_inv_d   = 1'b0;
      level_d      = 2'd0;
    end else begin
      unique case (level_q)
        2'd0: begin
          if (push) begin
            head_state_d = shifted;
            head_inv_d   = in_inv;
            level_d      = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_state_d = shifted;
            head_inv_d   = in_inv;
          end else if (push) begin
            tail_state_d = shifted;
            tail_inv_d   = in_inv;
            level_d      = 2'd2;
          end else if (pop) begin
            head_state_d = '0;
            head_inv_d   = 1'b0;
            level_d      = 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_state_d = tail_state_q;
            head_inv_d   = tail_inv_q;
            tail_state_d = '0;
            tail_inv_d   = 1'b0;
            level_d      = 2'd1;
          end
        end
      endcase
    end
  end

  // NOTE: the queue storage is reset, not just the occupancy, because out_state must read zero
  // (never X) straight out of reset and after a mid-stream reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_state_q <= '0;
      head_inv_q   <= 1'b0;
      tail_state_q <= '0;
      tail_inv_q   <= 1'b0;
      level_q      <= 2'd0;
    end else begin
      head_state_q <= head_state_d;
      head_inv_q   <= head_inv_d;
      tail_state_q <= tail_state_d;
      tail_inv_q   <= tail_inv_d;
      level_q      <= level_d;
    end
  end

  assign out_state = head_state_q;
  assign out_inv   = head_inv_q;
  assign level     = level_q;

endmodule
